// File: rtl/e_mem_port_ctrl.sv
// rtl/e_mem_port_ctrl.sv - multi-channel round-robin memory port with in-order read tag tracking
// Fabric channels share one registered memory request port; read data returns to the issuing channel.
module e_mem_port_ctrl #(
   parameter int N_CH            = 4,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     UserCLK,
   input  logic                     rst,
   input  logic [N_CH-1:0]          ch_req_valid,
   output logic [N_CH-1:0]          ch_req_ready,
   input  logic [N_CH-1:0]          ch_we,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_wdata,
   output logic [N_CH-1:0]          ch_rvalid,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [DATA_W-1:0]        mem_wdata_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [DATA_W-1:0]        mem_rdata_i,
   output logic                     rsp_err_o
);

   localparam int TAG_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [TAG_W-1:0]  rr_ptr;
   logic [TAG_W-1:0]  grant_idx;
   logic [TAG_W:0]    grant_sum;
   logic              grant_any;
   logic [N_CH-1:0]   eligible;
   logic [2*N_CH-1:0] elig_dbl;
   logic [N_CH-1:0]   elig_rot;
   logic              slot_free;
   logic              fifo_full;
   logic              push;
   logic              pop;

   logic [TAG_W-1:0]  tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic [ADDR_W-1:0] addr_arr  [N_CH];
   logic [DATA_W-1:0] wdata_arr [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign addr_arr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = ch_wdata[i*DATA_W +: DATA_W];
   end

   // A pop in the same cycle never frees room for a read granted in that cycle.
   assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
   assign slot_free = !mem_req_o || mem_gnt_i;
   assign eligible  = ch_req_valid & (ch_we | {N_CH{!fifo_full}});

   // Rotate eligibility so bit 0 is the channel at rr_ptr, then take the lowest set bit.
   assign elig_dbl = {eligible, eligible} >> rr_ptr;
   assign elig_rot = elig_dbl[N_CH-1:0];

   always_comb begin
      grant_sum = '0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (elig_rot[j]) begin
            grant_sum = {1'b0, rr_ptr} + (TAG_W+1)'(j);
         end
      end
      if (grant_sum >= (TAG_W+1)'(N_CH)) begin
         grant_sum = grant_sum - (TAG_W+1)'(N_CH);
      end
      grant_idx = grant_sum[TAG_W-1:0];
      grant_any = slot_free && (|elig_rot);
   end

   assign ch_req_ready = grant_any ? (N_CH'(1) << grant_idx) : '0;
   assign push         = grant_any && !ch_we[grant_idx];
   assign pop          = mem_rvalid_i && (count != '0);

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         rr_ptr      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         ch_rvalid   <= '0;
         ch_rdata    <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (grant_any) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= ch_we[grant_idx];
            mem_addr_o  <= addr_arr[grant_idx];
            mem_wdata_o <= wdata_arr[grant_idx];
            rr_ptr      <= (grant_idx == TAG_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
         end else if (slot_free) begin
            mem_req_o <= 1'b0;
         end

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            ch_rdata <= mem_rdata_i;
         end
         count     <= count + CNT_W'(push) - CNT_W'(pop);
         ch_rvalid <= pop ? (N_CH'(1) << tag_mem[rd_ptr]) : '0;

         if (mem_rvalid_i && (count == '0)) begin
            rsp_err_o <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge UserCLK) begin
      if (!rst && push) begin
         tag_mem[wr_ptr] <= grant_idx;
      end
   end

endmodule
